// File: rtl/mem_arb_pkg.sv
// Shared state encoding, owner codes and default widths for the memory-port arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_LINE_W = 128;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESP
  } arb_state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between the I-side and D-side requesters.
// MEM_PORT_ARB_RR_EN: ties alternate round-robin; otherwise D always wins a tie.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_valid,
  input  logic d_valid,
  input  logic rr_last,
  output logic grant_any,
  output logic grant_owner
);

  assign grant_any = i_valid | d_valid;

`ifdef MEM_PORT_ARB_RR_EN
  // On a tie, the side that did not win last time goes next.
  assign grant_owner = (i_valid && d_valid) ? ~rr_last : (d_valid ? OWN_D : OWN_I);
`else
  logic unused_rr_last;
  assign unused_rr_last = rr_last;
  assign grant_owner    = d_valid ? OWN_D : OWN_I;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one line-wide memory port between I-cache refill and D-cache refill/writeback.
// Optional macro MEM_PORT_ARB_RR_EN selects round-robin tie-breaking (default: fixed D priority).
//   state     | meaning
//   ARB_IDLE  | ready to grant; winner's req_ready asserted combinationally
//   ARB_ISSUE | mem_req_valid held with latched fields until mem_req_ready
//   ARB_WAIT  | waiting for mem_resp_valid; read data captured
//   ARB_RESP  | one-cycle response pulse to the owner
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_resp_valid,
  output logic [LINE_W-1:0] i_resp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_write,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [LINE_W-1:0] d_req_wdata,
  output logic              d_resp_valid,
  output logic [LINE_W-1:0] d_resp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [LINE_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [LINE_W-1:0] mem_resp_data
);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              rr_last;
  logic              grant_any;
  logic              grant_owner;
  logic              resp_pulse;

`ifdef MEM_PORT_ARB_RR_EN
  logic rr_last_q, rr_last_d;
  assign rr_last = rr_last_q;
`else
  assign rr_last = OWN_I;
`endif

  mem_arb_pick u_pick (
    .i_valid     (i_req_valid),
    .d_valid     (d_req_valid),
    .rr_last     (rr_last),
    .grant_any   (grant_any),
    .grant_owner (grant_owner)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
`ifdef MEM_PORT_ARB_RR_EN
    rr_last_d   = rr_last_q;
`endif
    i_req_ready = 1'b0;
    d_req_ready = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        // Ready is held low while reset is asserted so nothing is accepted then.
        if (!reset && grant_any) begin
          owner_d = grant_owner;
          state_d = ARB_ISSUE;
`ifdef MEM_PORT_ARB_RR_EN
          rr_last_d = grant_owner;
`endif
          if (grant_owner == OWN_D) begin
            d_req_ready = 1'b1;
            write_d     = d_req_write;
            addr_d      = d_req_addr;
            wdata_d     = d_req_wdata;
          end else begin
            i_req_ready = 1'b1;
            write_d     = 1'b0;
            addr_d      = i_req_addr;
            wdata_d     = '0;
          end
        end
      end
      ARB_ISSUE: begin
        if (mem_req_ready) state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (mem_resp_valid) begin
          rdata_d = write_q ? '0 : mem_resp_data;
          state_d = ARB_RESP;
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      owner_q   <= OWN_I;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
`ifdef MEM_PORT_ARB_RR_EN
      rr_last_q <= OWN_I;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
`ifdef MEM_PORT_ARB_RR_EN
      rr_last_q <= rr_last_d;
`endif
    end
  end

  assign mem_req_valid = (state_q == ARB_ISSUE);
  assign mem_req_write = (state_q == ARB_ISSUE) && write_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;

  assign resp_pulse   = (state_q == ARB_RESP);
  assign i_resp_valid = resp_pulse && (owner_q == OWN_I);
  assign d_resp_valid = resp_pulse && (owner_q == OWN_D);
  assign i_resp_data  = i_resp_valid ? rdata_q : '0;
  assign d_resp_data  = d_resp_valid ? rdata_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter with a behavioural memory and arbitration model.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req_valid, i_req_ready;
  logic [AW-1:0] i_req_addr;
  logic          i_resp_valid;
  logic [LW-1:0] i_resp_data;
  logic          d_req_valid, d_req_ready, d_req_write;
  logic [AW-1:0] d_req_addr;
  logic [LW-1:0] d_req_wdata;
  logic          d_resp_valid;
  logic [LW-1:0] d_resp_data;
  logic          mem_req_valid, mem_req_ready, mem_req_write;
  logic [AW-1:0] mem_req_addr;
  logic [LW-1:0] mem_req_wdata;
  logic          mem_resp_valid;
  logic [LW-1:0] mem_resp_data;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_write(d_req_write),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  typedef struct {int cyc; logic [LW-1:0] data;} pulse_t;
  typedef struct {logic write; logic [AW-1:0] addr; logic [LW-1:0] wdata; int len;} hs_t;

  pulse_t        ip_q[$], dp_q[$];
  int            gi_q[$], gd_q[$];
  logic          g_own_q[$], exp_own_q[$];
  hs_t           hs_q[$];
  logic [LW-1:0] store   [logic [AW-1:0]];
  logic [LW-1:0] ref_mem [logic [AW-1:0]];

  int checks = 0, errors = 0, cyc = 0;
  int lat = 0, rdy_dly = 0, seen = 0, resp_at = 0, two_ready = 0, unstable = 0;
  int i_rep = 0, d_rep = 0;
  bit resp_pend = 0, stray = 0, i_want = 0, d_want = 0, i_drop = 0, d_drop = 0;
  logic [AW-1:0] i_want_addr, d_want_addr, prev_ma;
  logic          d_want_write, prev_mv, prev_mw_en;
  logic [LW-1:0] d_want_wdata, prev_mw, resp_dat, rnd;
  logic          rr_last_m = 1'b0;

  function automatic logic [LW-1:0] dflt(input logic [AW-1:0] a);
    return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'd1};
  endfunction

  function automatic logic [LW-1:0] ref_read(input logic [AW-1:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return dflt(a);
  endfunction

  // Arbitration rule: 1 = D wins, 0 = I wins.
  function automatic logic model_pick(input bit iv, input bit dv);
    logic w;
`ifdef MEM_PORT_ARB_RR_EN
    if (iv && dv) w = ~rr_last_m;
    else          w = dv;
`else
    w = dv;
`endif
    rr_last_m = w;
    return w;
  endfunction

  // Grant order when ni I-requests and nd D-requests are all presented back to back.
  function automatic void model_order(input int ni, input int nd);
    logic w;
    while (ni > 0 || nd > 0) begin
      w = model_pick(ni > 0, nd > 0);
      exp_own_q.push_back(w);
      if (w) nd--; else ni--;
    end
  endfunction

  // Requesters, memory model and monitor, all stepped on the falling edge.
  initial begin : bus
    i_req_valid = 0; i_req_addr = '0; d_req_valid = 0; d_req_write = 0; d_req_addr = '0;
    d_req_wdata = '0; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
    prev_mv = 0; prev_ma = '0; prev_mw = '0; prev_mw_en = 0; resp_dat = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (i_drop) begin
        i_drop = 0;
        if (i_rep > 0) begin i_rep--; i_req_addr = i_req_addr + 32'h10; end
        else i_req_valid = 0;
      end
      if (i_want && !i_req_valid) begin i_req_valid = 1; i_req_addr = i_want_addr; i_want = 0; end
      if (d_drop) begin
        d_drop = 0;
        if (d_rep > 0) begin d_rep--; d_req_addr = d_req_addr + 32'h10; end
        else d_req_valid = 0;
      end
      if (d_want && !d_req_valid) begin
        d_req_valid = 1; d_req_addr = d_want_addr; d_req_write = d_want_write;
        d_req_wdata = d_want_wdata; d_want = 0;
      end
      mem_resp_valid = 0; mem_resp_data = '0;
      if (resp_pend && cyc == resp_at) begin
        mem_resp_valid = 1; mem_resp_data = resp_dat; resp_pend = 0;
      end
      if (stray) begin
        stray = 0; mem_resp_valid = 1;
        mem_resp_data = {$urandom, $urandom, $urandom, $urandom};
      end
      if (mem_req_valid) begin
        if (prev_mv && (mem_req_addr !== prev_ma || mem_req_wdata !== prev_mw ||
                        mem_req_write !== prev_mw_en)) unstable++;
        seen++;
        mem_req_ready = (seen > rdy_dly);
      end else begin
        seen = 0; mem_req_ready = 0;
      end
      prev_mv = mem_req_valid; prev_ma = mem_req_addr; prev_mw = mem_req_wdata;
      prev_mw_en = mem_req_write;
      if (mem_req_valid && mem_req_ready) begin
        hs_q.push_back('{mem_req_write, mem_req_addr, mem_req_wdata, seen});
        if (mem_req_write) begin
          store[mem_req_addr] = mem_req_wdata; resp_dat = '0;
        end else begin
          resp_dat = store.exists(mem_req_addr) ? store[mem_req_addr] : dflt(mem_req_addr);
        end
        resp_at = cyc + 1 + lat; resp_pend = 1;
      end
      #1;
      if (i_req_valid && i_req_ready) begin gi_q.push_back(cyc); g_own_q.push_back(1'b0); i_drop = 1; end
      if (d_req_valid && d_req_ready) begin gd_q.push_back(cyc); g_own_q.push_back(1'b1); d_drop = 1; end
      if (i_req_ready && d_req_ready) two_ready++;
      if (i_resp_valid) ip_q.push_back('{cyc, i_resp_data});
      if (d_resp_valid) dp_q.push_back('{cyc, d_resp_data});
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic wait_pulses(input int ni, input int nd, input int budget, output bit ok);
    int b = 0;
    while ((ip_q.size() < ni || dp_q.size() < nd) && b < budget) begin
      @(negedge clk); #2; b++;
    end
    ok = (ip_q.size() >= ni && dp_q.size() >= nd);
  endtask

  task automatic clr();
    ip_q.delete(); dp_q.delete(); gi_q.delete(); gd_q.delete();
    g_own_q.delete(); exp_own_q.delete(); hs_q.delete(); unstable = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    i_req_valid = 1; d_req_valid = 1; i_req_addr = 32'h44; d_req_addr = 32'h88;
    #1;
    checks++; if (i_req_ready !== 1'b0) begin errors++; $display("FAIL reset_i_ready: got %b want 0", i_req_ready); end
    checks++; if (d_req_ready !== 1'b0) begin errors++; $display("FAIL reset_d_ready: got %b want 0", d_req_ready); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid: got %b want 0", mem_req_valid); end
    checks++; if (mem_req_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %b want 0", mem_req_write); end
    checks++; if (mem_req_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_req_addr); end
    checks++; if (mem_req_wdata !== '0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", mem_req_wdata); end
    checks++; if (i_resp_valid !== 1'b0 || d_resp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_resp_valid: got i=%b d=%b want 0 0", i_resp_valid, d_resp_valid); end
    checks++; if (i_resp_data !== '0 || d_resp_data !== '0) begin
      errors++; $display("FAIL reset_resp_data: got i=%h d=%h want 0", i_resp_data, d_resp_data); end
    i_req_valid = 0; d_req_valid = 0;
    @(negedge clk); #2;
    reset = 1'b0;
    rr_last_m = 1'b0;
    wait_cyc(2);
    checks++; if (g_own_q.size() != 0) begin errors++; $display("FAIL reset_no_grant: got %0d grants want 0", g_own_q.size()); end
  endtask

  task automatic test_lone_read();
    bit ok;
    clr(); lat = 3; rdy_dly = 0;
    store[32'h100] = {16{8'hA5}}; ref_mem[32'h100] = {16{8'hA5}};
    exp_own_q.delete(); model_order(1, 0);
    i_want_addr = 32'h100; i_want = 1;
    wait_pulses(1, 0, 50, ok);
    wait_cyc(4);
    checks++; if (!ok) begin errors++; $display("FAIL lone_timeout: got %0d i pulses want 1", ip_q.size()); end
    checks++; if (ip_q.size() != 1) begin errors++; $display("FAIL lone_pulse_width: got %0d pulse cycles want 1", ip_q.size()); end
    checks++; if (ip_q[0].cyc - gi_q[0] != 6) begin
      errors++; $display("FAIL lone_latency: got %0d want 6", ip_q[0].cyc - gi_q[0]); end
    checks++; if (ip_q[0].data !== {16{8'hA5}}) begin errors++; $display("FAIL lone_data: got %h want a5..a5", ip_q[0].data); end
    checks++; if (dp_q.size() != 0) begin errors++; $display("FAIL lone_d_quiet: got %0d d pulses want 0", dp_q.size()); end
    checks++; if (hs_q[0].addr !== 32'h100 || hs_q[0].write !== 1'b0) begin
      errors++; $display("FAIL lone_mem_req: got addr %h wr %b want 100 0", hs_q[0].addr, hs_q[0].write); end
  endtask

  task automatic test_simultaneous();
    bit ok;
    int first_resp, second_gnt;
    clr(); lat = 2; rdy_dly = 0;
    model_order(1, 1);
    i_want_addr = 32'h200; d_want_addr = 32'h300; d_want_write = 0; d_want_wdata = '0;
    i_want = 1; d_want = 1;
    wait_pulses(1, 1, 80, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sim_timeout: got i=%0d d=%0d want 1 1", ip_q.size(), dp_q.size()); end
    for (int k = 0; k < 2; k++) begin
      checks++; if (g_own_q[k] !== exp_own_q[k]) begin
        errors++; $display("FAIL sim_order[%0d]: got %b want %b", k, g_own_q[k], exp_own_q[k]); end
    end
    checks++; if (hs_q[0].addr !== (exp_own_q[0] ? 32'h300 : 32'h200)) begin
      errors++; $display("FAIL sim_first_addr: got %h want %h", hs_q[0].addr, exp_own_q[0] ? 32'h300 : 32'h200); end
    first_resp = exp_own_q[0] ? dp_q[0].cyc : ip_q[0].cyc;
    second_gnt = exp_own_q[0] ? gi_q[0] : gd_q[0];
    checks++; if (second_gnt - first_resp != 1) begin
      errors++; $display("FAIL sim_gap: got %0d want 1", second_gnt - first_resp); end
    checks++; if (ip_q[0].data !== ref_read(32'h200)) begin errors++; $display("FAIL sim_i_data: got %h want %h", ip_q[0].data, ref_read(32'h200)); end
    checks++; if (dp_q[0].data !== ref_read(32'h300)) begin errors++; $display("FAIL sim_d_data: got %h want %h", dp_q[0].data, ref_read(32'h300)); end
  endtask

  task automatic test_writeback_stall();
    bit ok;
    clr(); lat = 2; rdy_dly = 4;
    model_order(0, 1);
    ref_mem[32'h40] = 128'h1234;
    d_want_addr = 32'h40; d_want_write = 1; d_want_wdata = 128'h1234; d_want = 1;
    wait_pulses(0, 1, 80, ok);
    wait_cyc(3);
    checks++; if (!ok) begin errors++; $display("FAIL wb_timeout: got %0d d pulses want 1", dp_q.size()); end
    checks++; if (hs_q[0].len != 5) begin errors++; $display("FAIL wb_hold_len: got %0d want 5", hs_q[0].len); end
    checks++; if (hs_q[0].write !== 1'b1) begin errors++; $display("FAIL wb_write: got %b want 1", hs_q[0].write); end
    checks++; if (hs_q[0].addr !== 32'h40) begin errors++; $display("FAIL wb_addr: got %h want 40", hs_q[0].addr); end
    checks++; if (hs_q[0].wdata !== 128'h1234) begin errors++; $display("FAIL wb_wdata: got %h want 1234", hs_q[0].wdata); end
    checks++; if (unstable != 0) begin errors++; $display("FAIL wb_stable: got %0d changes want 0", unstable); end
    checks++; if (dp_q.size() != 1) begin errors++; $display("FAIL wb_pulse_width: got %0d want 1", dp_q.size()); end
    checks++; if (dp_q[0].data !== '0) begin errors++; $display("FAIL wb_ack_data: got %h want 0", dp_q[0].data); end
    checks++; if (dp_q[0].cyc - gd_q[0] != 9) begin errors++; $display("FAIL wb_latency: got %0d want 9", dp_q[0].cyc - gd_q[0]); end
    checks++; if (ip_q.size() != 0) begin errors++; $display("FAIL wb_i_quiet: got %0d want 0", ip_q.size()); end
  endtask

  task automatic test_stray_and_reset();
    bit ok;
    int b, post_cyc;
    clr(); lat = 8; rdy_dly = 0;
    stray = 1;
    wait_cyc(4);
    checks++; if (ip_q.size() + dp_q.size() != 0) begin
      errors++; $display("FAIL stray_pulse: got %0d pulses want 0", ip_q.size() + dp_q.size()); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL stray_mem_valid: got %b want 0", mem_req_valid); end
    i_want_addr = 32'h500; i_want = 1;
    b = 0;
    while (hs_q.size() == 0 && b < 20) begin @(negedge clk); #2; b++; end
    checks++; if (hs_q.size() == 0) begin errors++; $display("FAIL rst_issue_timeout: got 0 handshakes want 1"); end
    @(negedge clk); #2; reset = 1'b1;
    @(negedge clk); #2; reset = 1'b0;
    rr_last_m = 1'b0;
    wait_cyc(12);
    checks++; if (ip_q.size() + dp_q.size() != 0) begin
      errors++; $display("FAIL rst_dropped: got %0d pulses want 0", ip_q.size() + dp_q.size()); end
    lat = 2;
    model_order(0, 1);
    d_want_addr = 32'h600; d_want_write = 0; d_want_wdata = '0; d_want = 1;
    post_cyc = cyc;
    wait_pulses(0, 1, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_next_timeout: got %0d d pulses want 1", dp_q.size()); end
    checks++; if (gd_q[0] != post_cyc + 1) begin errors++; $display("FAIL rst_idle_grant: got cycle %0d want %0d", gd_q[0], post_cyc + 1); end
    checks++; if (dp_q[0].data !== ref_read(32'h600)) begin errors++; $display("FAIL rst_next_data: got %h want %h", dp_q[0].data, ref_read(32'h600)); end
    checks++; if (dp_q[0].cyc - gd_q[0] != 5) begin errors++; $display("FAIL rst_next_latency: got %0d want 5", dp_q[0].cyc - gd_q[0]); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clr(); lat = 1; rdy_dly = 0;
    model_order(4, 4);
    i_rep = 3; d_rep = 3;
    i_want_addr = 32'h700; d_want_addr = 32'h800; d_want_write = 0; d_want_wdata = '0;
    i_want = 1; d_want = 1;
    wait_pulses(4, 4, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: got i=%0d d=%0d want 4 4", ip_q.size(), dp_q.size()); end
    for (int k = 0; k < 8; k++) begin
      checks++; if (g_own_q[k] !== exp_own_q[k]) begin
        errors++; $display("FAIL b2b_order[%0d]: got %b want %b", k, g_own_q[k], exp_own_q[k]); end
    end
    for (int k = 0; k < 4; k++) begin
      checks++; if (ip_q[k].data !== ref_read(32'h700 + 32'(k * 16))) begin
        errors++; $display("FAIL b2b_i_data[%0d]: got %h want %h", k, ip_q[k].data, ref_read(32'h700 + 32'(k * 16))); end
      checks++; if (dp_q[k].data !== ref_read(32'h800 + 32'(k * 16))) begin
        errors++; $display("FAIL b2b_d_data[%0d]: got %h want %h", k, dp_q[k].data, ref_read(32'h800 + 32'(k * 16))); end
      checks++; if (ip_q[k].cyc - gi_q[k] != 4 || dp_q[k].cyc - gd_q[k] != 4) begin
        errors++; $display("FAIL b2b_latency[%0d]: got i=%0d d=%0d want 4", k, ip_q[k].cyc - gi_q[k], dp_q[k].cyc - gd_q[k]); end
    end
  endtask

  task automatic test_random();
    bit ok;
    int mode, ni, nd;
    logic [AW-1:0] ia, da;
    logic [LW-1:0] ei, ed;
    for (int it = 0; it < 20; it++) begin
      clr();
      mode = $urandom_range(0, 2);
      lat = $urandom_range(0, 5); rdy_dly = $urandom_range(0, 3);
      ni = (mode != 1) ? 1 : 0; nd = (mode != 0) ? 1 : 0;
      ia = 32'h1000 + ($urandom_range(0, 15) << 4);
      da = 32'h2000 + ($urandom_range(0, 7) << 4);
      rnd = {$urandom, $urandom, $urandom, $urandom};
      ei = ref_read(ia);
      d_want_write = 1'($urandom_range(0, 1));
      if (nd == 1 && d_want_write) begin ref_mem[da] = rnd; ed = '0; end
      else ed = ref_read(da);
      model_order(ni, nd);
      i_want_addr = ia; d_want_addr = da; d_want_wdata = rnd;
      i_want = (ni == 1); d_want = (nd == 1);
      wait_pulses(ni, nd, 100, ok);
      wait_cyc(2);
      checks++; if (!ok || ip_q.size() != ni || dp_q.size() != nd) begin
        errors++; $display("FAIL rnd%0d_count: got i=%0d d=%0d want %0d %0d", it, ip_q.size(), dp_q.size(), ni, nd); end
      for (int k = 0; k < ni + nd; k++) begin
        checks++; if (g_own_q[k] !== exp_own_q[k]) begin
          errors++; $display("FAIL rnd%0d_order[%0d]: got %b want %b", it, k, g_own_q[k], exp_own_q[k]); end
      end
      if (ni == 1) begin
        checks++; if (ip_q[0].data !== ei || ip_q[0].cyc - gi_q[0] != lat + rdy_dly + 3) begin
          errors++; $display("FAIL rnd%0d_i: got %h lat %0d want %h lat %0d", it, ip_q[0].data, ip_q[0].cyc - gi_q[0], ei, lat + rdy_dly + 3); end
      end
      if (nd == 1) begin
        checks++; if (dp_q[0].data !== ed || dp_q[0].cyc - gd_q[0] != lat + rdy_dly + 3) begin
          errors++; $display("FAIL rnd%0d_d: got %h lat %0d want %h lat %0d", it, dp_q[0].data, dp_q[0].cyc - gd_q[0], ed, lat + rdy_dly + 3); end
      end
    end
    checks++; if (two_ready != 0) begin errors++; $display("FAIL one_ready: got %0d dual-ready cycles want 0", two_ready); end
  endtask

  initial begin : main
    reset = 1'b1;
    test_reset();
    test_lone_read();
    test_simultaneous();
    test_writeback_stall();
    test_stray_and_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
